cbi980_axil_master: RTL and testbench

- AXI4-Lite initiator: converts a simple single-outstanding command/response stream into AXI4-Lite read and write transactions.
- Used to drive the CBI980 register slave from on-chip sequencers and bring-up logic, and as the bus-side driver in integration benches.
- One transaction in flight at a time; a timeout watchdog flags hung slaves.

---
 rtl/cbi980_axil_master.sv | 207 ++++++++++++++++++++
 tb/tb_cbi980_axil_master.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbi980_axil_master.sv
// Single-outstanding command/response to AXI4-Lite initiator with a
// per-transaction watchdog. A hung slave parks the block until reset.
module cbi980_axil_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              aclk,
  input  logic              arstn,
  // command / response stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              hung,
  // AXI write address
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  // AXI write data
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  // AXI write response
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // AXI read address
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  // AXI read data
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  // Wide enough to hold TIMEOUT itself; the counter saturates there.
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    IDLE,  // waiting for a command
    WR,    // AW and W outstanding (each may finish first)
    WB,    // waiting for the write response
    RA,    // AR outstanding
    RD,    // waiting for read data
    RSP    // presenting the response
  } state_t;

  state_t              state_q, state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_d;
  logic [3:0]          wstrb_d;
  logic [31:0]         rsp_rdata_d;
  logic [1:0]          rsp_resp_d;
  logic                rsp_timeout_d;
  logic                hung_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                cmd_hs;
  logic                busy;
  logic                timeout_hit;

  // Handshake-facing outputs decode straight from registered state.
  assign cmd_ready = (state_q == IDLE) && !hung;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign awvalid   = (state_q == WR) && !aw_done_q;
  assign wvalid    = (state_q == WR) && !w_done_q;
  assign bready    = (state_q == WB);
  assign arvalid   = (state_q == RA);
  assign rready    = (state_q == RD);
  assign rsp_valid = (state_q == RSP);
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awcache   = 4'b0000;
  assign arcache   = 4'b0000;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;

  // The watchdog fires on the edge where the count would reach TIMEOUT.
  assign busy        = (state_q == WR) || (state_q == WB) ||
                       (state_q == RA) || (state_q == RD);
  assign timeout_hit = (TIMEOUT != 0) && busy && ((int'(cnt_q) + 1) >= TIMEOUT);

  // Next-state and captured-response logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    addr_d        = addr_q;
    wdata_d       = wdata;
    wstrb_d       = wstrb;
    rsp_rdata_d   = rsp_rdata;
    rsp_resp_d    = rsp_resp;
    rsp_timeout_d = rsp_timeout;
    hung_d        = hung;

    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d    = cmd_addr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            wdata_d = cmd_wdata;
            wstrb_d = cmd_wstrb;
            state_d = WR;
          end else begin
            state_d = RA;
          end
        end
      end
      WR: begin
        // A ready seen while the channel is still open is its handshake.
        aw_done_d = aw_done_q || awready;
        w_done_d  = w_done_q || wready;
        if (aw_done_d && w_done_d) state_d = WB;
      end
      WB: begin
        if (bvalid) begin
          rsp_resp_d    = bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end
      end
      RA: begin
        if (arready) state_d = RD;
      end
      RD: begin
        if (rvalid) begin
          rsp_rdata_d   = rdata;
          rsp_resp_d    = rresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A phase that completes on the expiry edge has already left its state,
    // so the slave wins that race; only a stalled phase is aborted.
    if (timeout_hit && (state_d == state_q)) begin
      state_d       = RSP;
      hung_d        = 1'b1;
      rsp_resp_d    = 2'b11;
      rsp_timeout_d = 1'b1;
      rsp_rdata_d   = '0;
    end
  end

  // State, payload and watchdog registers with synchronous reset.
  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values regardless of statement order.
    if (!arstn) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      hung        <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
      cnt_q       <= '0;
      // NOTE: the payload registers are reset as well so the bus never
      // shows X after reset; they are plain flops, not a memory array.
      addr_q      <= '0;
      wdata       <= '0;
      wstrb       <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      hung        <= hung_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_resp    <= rsp_resp_d;
      rsp_timeout <= rsp_timeout_d;
      addr_q      <= addr_d;
      wdata       <= wdata_d;
      wstrb       <= wstrb_d;
      if (cmd_hs) begin
        cnt_q <= '0;
      end else if (busy && (int'(cnt_q) < TIMEOUT)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cbi980_axil_master.sv
// Directed bench for cbi980_axil_master: a behavioural AXI-Lite slave with
// programmable wait states, an expected-response queue, and one monitor that
// checks bus and response behaviour every cycle against that queue.
module tb_cbi980_axil_master;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              aclk = 1'b0;
  logic              arstn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [31:0]       cmd_wdata = '0;
  logic [3:0]        cmd_wstrb = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;
  logic              hung;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready = 1'b0;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready = 1'b0;
  logic [1:0]        bresp = '0;
  logic              bvalid = 1'b0;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [31:0]       rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rvalid = 1'b0;
  logic              rready;

  always #5 aclk = ~aclk;

  cbi980_axil_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .arstn(arstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .hung(hung),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .awcache(awcache), .awprot(awprot),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .arcache(arcache), .arprot(arprot),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural slave ----------------
  int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0;
  int          cfg_ar_wait = 0, cfg_r_wait = 0;
  bit          cfg_ar_never = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;

  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_got, w_got, ar_got, b_hs, r_hs;
  int b_count = 0;

  task automatic set_slave(input int aw_w, input int w_w, input int b_w, input int ar_w,
                           input int r_w, input bit never, input logic [1:0] br,
                           input logic [1:0] rr, input logic [31:0] rd);
    cfg_aw_wait = aw_w; cfg_w_wait = w_w; cfg_b_wait = b_w;
    cfg_ar_wait = ar_w; cfg_r_wait = r_w; cfg_ar_never = never;
    cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd;
  endtask

  // Readies raised at a negedge complete a handshake at the following posedge.
  always @(negedge aclk) begin
    if (!arstn) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
    end else begin
      if (awready) begin awready = 0; aw_got = 1; end
      else if (awvalid) begin
        if (aw_cnt >= cfg_aw_wait) begin awready = 1; aw_cnt = 0; end else aw_cnt++;
      end
      if (wready) begin wready = 0; w_got = 1; end
      else if (wvalid) begin
        if (w_cnt >= cfg_w_wait) begin wready = 1; w_cnt = 0; end else w_cnt++;
      end
      if (b_hs) begin bvalid = 0; b_hs = 0; b_count++; end
      else if (!bvalid && aw_got && w_got) begin
        if (b_cnt >= cfg_b_wait) begin
          bvalid = 1; bresp = cfg_bresp; aw_got = 0; w_got = 0; b_cnt = 0;
        end else b_cnt++;
      end
      if (bvalid && bready) b_hs = 1;
      if (arready) begin arready = 0; ar_got = 1; end
      else if (arvalid && !cfg_ar_never) begin
        if (ar_cnt >= cfg_ar_wait) begin arready = 1; ar_cnt = 0; end else ar_cnt++;
      end
      if (r_hs) begin rvalid = 0; r_hs = 0; end
      else if (!rvalid && ar_got) begin
        if (r_cnt >= cfg_r_wait) begin
          rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; ar_got = 0; r_cnt = 0;
        end else r_cnt++;
      end
      if (rvalid && rready) r_hs = 1;
    end
  end

  // ---------------- model and monitor ----------------
  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    bit          to;
  } exp_t;

  exp_t exp_q[$];
  bit   in_flight = 0;
  bit   hung_model = 0;
  logic prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr, prev_bry, prev_bv;
  exp_t e;

  always begin
    @(negedge aclk);
    #1;
    if (!arstn) begin
      in_flight = 0; hung_model = 0; exp_q.delete();
      prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0;
      prev_arv = 0; prev_arr = 0; prev_bry = 0; prev_bv = 0;
    end else begin
      check("cmd_ready", cmd_ready, !in_flight && !hung_model);
      check("cache_prot", {awcache, arcache, awprot, arprot}, 14'd0);
      if (!in_flight) begin
        check("idle_bus", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'd0);
        check("idle_hung", hung, hung_model);
      end else if (exp_q.size() == 0) begin
        check("exp_queue", exp_q.size(), 1);
      end else begin
        e = exp_q[0];
        if (awvalid) check("awaddr", {e.is_write, awaddr}, {1'b1, e.addr});
        if (wvalid)  check("wdata_wstrb", {e.is_write, wdata, wstrb}, {1'b1, e.wdata, e.wstrb});
        if (arvalid) check("araddr", {e.is_write, araddr}, {1'b0, e.addr});
        if (!e.to) begin
          if (prev_awv && !prev_awr) check("aw_hold", awvalid, 1'b1);
          if (prev_wv && !prev_wr)   check("w_hold", wvalid, 1'b1);
          if (prev_arv && !prev_arr) check("ar_hold", arvalid, 1'b1);
          if (prev_bry && !prev_bv)  check("b_hold", bready, 1'b1);
        end
        if (rsp_valid) begin
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", rsp_resp, e.resp);
          check("rsp_timeout", rsp_timeout, e.to);
          check("rsp_hung", hung, hung_model || e.to);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            in_flight = 0;
            if (e.to) hung_model = 1;
          end
        end
      end
      if (cmd_valid && cmd_ready) in_flight = 1;
      prev_awv = awvalid; prev_awr = awready; prev_wv = wvalid; prev_wr = wready;
      prev_arv = arvalid; prev_arr = arready; prev_bry = bready; prev_bv = bvalid;
    end
  end

  // ---------------- driver ----------------
  logic [31:0] got_rdata;
  logic [1:0]  got_resp;
  logic        got_to, got_hung;

  task automatic push_exp(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [31:0] e_rd,
                          input logic [1:0] e_resp, input bit e_to);
    exp_t x;
    x.is_write = wr; x.addr = addr; x.wdata = wd; x.wstrb = ws;
    x.rdata = e_rd; x.resp = e_resp; x.to = e_to;
    exp_q.push_back(x);
  endtask

  // Returns at the negedge following the accepting edge.
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] e_rd,
                        input logic [1:0] e_resp, input bit e_to);
    int n = 0;
    push_exp(wr, addr, wd, ws, e_rd, e_resp, e_to);
    @(negedge aclk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    while (!cmd_ready && n < 64) begin @(negedge aclk); n++; end
    check("cmd_accept", cmd_ready, 1'b1);
    @(negedge aclk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int hold);
    int n = 0;
    @(negedge aclk);
    while (!rsp_valid && n < 64) begin @(negedge aclk); n++; end
    check("rsp_arrive", rsp_valid, 1'b1);
    if (rsp_valid) begin
      repeat (hold) @(negedge aclk);
      rsp_ready = 1;
      got_rdata = rsp_rdata; got_resp = rsp_resp; got_to = rsp_timeout; got_hung = hung;
      @(negedge aclk);
      rsp_ready = 0;
    end
  endtask

  initial begin
    int          n;
    bit          seen;
    int          b_before;
    logic [31:0] held;

    // reset
    repeat (2) @(negedge aclk);
    #2;
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'd0);
    check("rst_hung_rsp", {hung, rsp_timeout, rsp_resp, rsp_rdata}, 36'd0);
    @(negedge aclk);
    arstn = 1;
    #2;
    check("rst_cmd_ready", cmd_ready, 1'b1);

    // 1: zero-wait write
    set_slave(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    do_cmd(1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 0);
    #2;
    check("t1_valids", {awvalid, wvalid}, 2'b11);
    check("t1_payload", {awaddr, wdata, wstrb}, {32'h4, 32'hDEAD_BEEF, 4'hF});
    seen = 0;
    repeat (4) begin
      if (bready) seen = 1;
      @(negedge aclk); #2;
    end
    check("t1_bready", seen, 1'b1);
    wait_rsp(0);
    check("t1_rsp", {got_rdata, got_resp, got_to}, {32'h0, 2'b00, 1'b0});

    // 2: read with three wait cycles before arready
    set_slave(0, 0, 0, 3, 0, 0, 2'b00, 2'b00, 32'h1234_5678);
    do_cmd(0, 32'h0000_0008, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 0);
    n = 0;
    #2;
    while (arvalid && n < 64) begin n++; @(negedge aclk); #2; end
    check("t2_arvalid_cycles", n, 4);
    wait_rsp(0);
    check("t2_rsp", {got_rdata, got_resp, got_to}, {32'h1234_5678, 2'b00, 1'b0});

    // 3: W accepted two cycles before AW
    set_slave(2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    b_before = b_count;
    do_cmd(1, 32'h0000_000C, 32'hA5A5_0F0F, 4'hF, 32'h0, 2'b00, 0);
    @(negedge aclk); #2;
    check("t3_w_first", {wvalid, awvalid}, 2'b01);
    wait_rsp(0);
    check("t3_rsp", {got_resp, got_to}, {2'b00, 1'b0});
    repeat (2) @(negedge aclk);
    check("t3_b_count", b_count - b_before, 1);

    // 4: SLVERR write then SLVERR read, neither sticky
    set_slave(0, 0, 1, 0, 0, 0, 2'b10, 2'b10, 32'hCAFE_F00D);
    do_cmd(1, 32'h0000_0010, 32'h0000_BEEF, 4'h3, 32'h0, 2'b10, 0);
    wait_rsp(0);
    check("t4_wr_rsp", {got_resp, got_to, got_hung}, {2'b10, 1'b0, 1'b0});
    do_cmd(0, 32'h0000_0008, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b10, 0);
    wait_rsp(0);
    check("t4_rd_rsp", {got_rdata, got_resp, got_hung}, {32'hCAFE_F00D, 2'b10, 1'b0});

    // 5: response back-pressure with the next command already waiting
    set_slave(0, 0, 0, 1, 2, 0, 2'b00, 2'b00, 32'h0BAD_F00D);
    do_cmd(0, 32'h0000_0014, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 0);
    push_exp(1, 32'h0000_0018, 32'h1111_2222, 4'hC, 32'h0, 2'b00, 0);
    n = 0;
    while (!rsp_valid && n < 64) begin @(negedge aclk); n++; end
    check("t5_rsp_arrive", rsp_valid, 1'b1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h18; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hC;
    held = rsp_rdata;
    repeat (5) begin
      @(negedge aclk);
      check("t5_hold", {rsp_valid, rsp_rdata, cmd_ready}, {1'b1, 32'h0BAD_F00D, 1'b0});
    end
    check("t5_held_data", held, 32'h0BAD_F00D);
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
    check("t5_cmd_ready_after", cmd_ready, 1'b1);
    @(negedge aclk);
    cmd_valid = 0;
    wait_rsp(0);
    check("t5_wr_rsp", {got_rdata, got_resp}, {32'h0, 2'b00});

    // 6: AR never accepted -> watchdog after TIMEOUT cycles, sticky hung
    set_slave(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 32'h0);
    do_cmd(0, 32'h0000_0020, 32'h0, 4'h0, 32'h0, 2'b11, 1);
    n = 0;
    #2;
    while (arvalid && n < 64) begin n++; @(negedge aclk); #2; end
    check("t6_arvalid_cycles", n, 16);
    wait_rsp(0);
    check("t6_rsp", {got_rdata, got_resp, got_to, got_hung}, {32'h0, 2'b11, 1'b1, 1'b1});
    @(negedge aclk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h28;
    repeat (5) begin
      @(negedge aclk); #2;
      check("t6_blocked", {cmd_ready, hung}, 2'b01);
    end
    @(negedge aclk);
    cmd_valid = 0;
    arstn = 0;
    repeat (2) @(negedge aclk);
    arstn = 1;
    #2;
    check("t6_after_reset", {cmd_ready, hung, rsp_valid, rsp_timeout, rsp_resp}, 6'b100000);

    // 7: normal read after recovery
    set_slave(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h5555_AAAA);
    do_cmd(0, 32'h0000_0024, 32'h0, 4'h0, 32'h5555_AAAA, 2'b00, 0);
    wait_rsp(0);
    check("t7_rsp", {got_rdata, got_resp, got_to}, {32'h5555_AAAA, 2'b00, 1'b0});

    repeat (3) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
